// File: rtl/imem_pkg.sv
// Shared types and constants for the instruction-memory responder.
package imem_pkg;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  localparam logic [31:0] NOP_INSTR = 32'h00000013;
  localparam int          WCNT_W    = 2;

  // Misaligned byte address, or word index past the end of the array.
  function automatic logic addr_bad(input logic [31:0] a, input int unsigned depth);
    return (a[1:0] != 2'b00) || ({2'b00, a[31:2]} >= depth);
  endfunction

endpackage

// File: rtl/imem_array.sv
// Instruction storage: one synchronous read port, one synchronous write port, read-before-write.
module imem_array #(
  parameter int DEPTH_WORDS = 1024,
  parameter int AW          = $clog2(DEPTH_WORDS)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [31:0]   wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH_WORDS];

  // Both ports in one block: the read samples the pre-write contents.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/imem_responder.sv
// Single-outstanding fetch responder with programmable wait states and a side loader port.
module imem_responder
  import imem_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_STATES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_instr,
  output logic        rsp_err,
  input  logic        ld_en,
  input  logic [31:0] ld_addr,
  input  logic [31:0] ld_data
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [WCNT_W-1:0] CNT_INIT = WCNT_W'(WAIT_STATES > 0 ? WAIT_STATES - 1 : 0);

  state_t            state;
  logic [WCNT_W-1:0] cnt;
  logic [31:0]       addr_q;
  logic [31:0]       rdata;
  logic              accept;
  logic              rd_en;
  logic [AW-1:0]     rd_idx;
  logic              wr_en;

  // Loader owns the cycle when it strobes, so a fetch waits.
  assign req_ready = (state == IDLE) && !ld_en && !rst;
  assign accept    = req_valid && req_ready;
  assign wr_en     = ld_en && !addr_bad(ld_addr, DEPTH_WORDS);
  assign rsp_instr = rsp_err ? NOP_INSTR : (rsp_valid ? rdata : '0);

  // Read fires on the edge that enters RESP; faulting addresses read harmlessly but are masked.
  always_comb begin
    rd_en  = 1'b0;
    rd_idx = addr_q[AW+1:2];
    if (state == IDLE) begin
      rd_en  = accept && (WAIT_STATES == 0);
      rd_idx = req_addr[AW+1:2];
    end else if (state == WAIT) begin
      rd_en  = (cnt == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      addr_q    <= '0;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          addr_q <= req_addr;
          if (WAIT_STATES == 0) begin
            state     <= RESP;
            rsp_valid <= 1'b1;
            rsp_err   <= addr_bad(req_addr, DEPTH_WORDS);
          end else begin
            state <= WAIT;
            cnt   <= CNT_INIT;
          end
        end
        WAIT: if (cnt == '0) begin
          state     <= RESP;
          rsp_valid <= 1'b1;
          rsp_err   <= addr_bad(addr_q, DEPTH_WORDS);
        end else begin
          cnt <= cnt - 1'b1;
        end
        RESP: if (rsp_ready) begin
          state     <= IDLE;
          rsp_valid <= 1'b0;
          rsp_err   <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  imem_array #(.DEPTH_WORDS(DEPTH_WORDS), .AW(AW)) u_array (
    .clk   (clk),
    .we    (wr_en),
    .waddr (ld_addr[AW+1:2]),
    .wdata (ld_data),
    .re    (rd_en),
    .raddr (rd_idx),
    .rdata (rdata)
  );

endmodule

// File: tb/tb_imem_responder.sv
// Randomized + directed scoreboard bench for imem_responder against a transaction-level memory model.
module tb_imem_responder;

  localparam int DEPTH = 64;
  localparam int WS    = 1;
  localparam logic [31:0] NOP = 32'h00000013;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1, req_valid = 1'b0, rsp_ready = 1'b1, ld_en = 1'b0;
  logic [31:0] req_addr = '0, ld_addr = '0, ld_data = '0;
  logic        req_ready, rsp_valid, rsp_err;
  logic [31:0] rsp_instr;

  imem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(WS)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_instr(rsp_instr), .rsp_err(rsp_err),
    .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data)
  );

  // Side instances for latency of the other wait-state builds.
  logic        l_req = 1'b0, l_ld = 1'b0;
  logic [31:0] l_ld_data = '0;
  logic        r0_ready, r0_valid, r0_err, r3_ready, r3_valid, r3_err;
  logic [31:0] r0_instr, r3_instr;

  imem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(0)) u_ws0 (
    .clk(clk), .rst(rst), .req_valid(l_req), .req_ready(r0_ready), .req_addr(32'h0),
    .rsp_valid(r0_valid), .rsp_ready(1'b1), .rsp_instr(r0_instr), .rsp_err(r0_err),
    .ld_en(l_ld), .ld_addr(32'h0), .ld_data(l_ld_data)
  );
  imem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(3)) u_ws3 (
    .clk(clk), .rst(rst), .req_valid(l_req), .req_ready(r3_ready), .req_addr(32'h0),
    .rsp_valid(r3_valid), .rsp_ready(1'b1), .rsp_instr(r3_instr), .rsp_err(r3_err),
    .ld_en(l_ld), .ld_addr(32'h0), .ld_data(l_ld_data)
  );

  typedef struct { logic [31:0] instr; logic err; } exp_t;
  exp_t exp_q[$];

  int checks = 0, errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, req, $time);
    end
  endtask

  // Reference model: one outstanding fetch, memory read at accept edge + WS, before that edge's write.
  logic [31:0] mem [DEPTH];
  int          cyc = 0, read_c = 0, acc_cnt = 0;
  bit          busy = 0, rst_last = 0, started = 0;
  logic [31:0] req_a = '0;

  function automatic exp_t lookup(input logic [31:0] a);
    exp_t e;
    if (a % 4 != 0 || a / 4 >= DEPTH) begin e.instr = NOP; e.err = 1'b1; end
    else begin e.instr = mem[a / 4]; e.err = 1'b0; end
    return e;
  endfunction

  initial forever begin
    @(posedge clk);
    cyc++;
    rst_last = rst;
    if (rst) busy = 0;
    else if (busy) begin
      if (cyc == read_c) exp_q.push_back(lookup(req_a));
      else if (cyc > read_c && rsp_ready) busy = 0;
    end else if (req_valid && !ld_en) begin
      busy = 1; req_a = req_addr; read_c = cyc + WS; acc_cnt++;
      if (WS == 0) exp_q.push_back(lookup(req_a));
    end
    if (ld_en && ld_addr % 4 == 0 && ld_addr / 4 < DEPTH) mem[ld_addr / 4] = ld_data;
  end

  // Monitor: samples mid-low-phase, pops one expectation per response and checks it every held cycle.
  exp_t cur;
  bit   active = 0;
  initial forever begin
    @(negedge clk); #2;
    if (started) begin
      if (rst_last) begin
        chk("reset_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        chk("reset_rsp_instr", rsp_instr, 32'd0);
        chk("reset_rsp_err", {31'b0, rsp_err}, 32'd0);
      end
      chk("rsp_valid", {31'b0, rsp_valid}, {31'b0, busy && cyc >= read_c});
      chk("req_ready", {31'b0, req_ready}, {31'b0, !busy && !ld_en && !rst});
      if (rsp_valid) begin
        if (!active) begin
          if (exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_rsp actual=%h required=none", rsp_instr);
          end else begin
            cur = exp_q.pop_front(); active = 1;
          end
        end
        if (active) begin
          chk("rsp_instr", rsp_instr, cur.instr);
          chk("rsp_err", {31'b0, rsp_err}, {31'b0, cur.err});
        end
        if (rsp_ready) active = 0;
      end
      if (rst) active = 0;
    end
  end

  task automatic issue(input logic [31:0] a);
    int n0 = acc_cnt;
    req_valid = 1'b1; req_addr = a;
    for (int i = 0; i < 20 && acc_cnt == n0; i++) @(negedge clk);
    req_valid = 1'b0;
    checks++;
    if (acc_cnt == n0) begin errors++; $display("FAIL accept_timeout actual=none required=accept addr=%h", a); end
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 60 && busy; i++) @(negedge clk);
    checks++;
    if (busy) begin errors++; $display("FAIL idle_timeout actual=busy required=idle"); end
  endtask

  task automatic do_req(input logic [31:0] a);
    issue(a); wait_idle();
  endtask

  function automatic logic [31:0] rnd_addr();
    logic [31:0] a;
    case ($urandom_range(0, 9))
      0:       a = $urandom;
      1:       a = ($urandom_range(0, DEPTH + 4) * 4) | $urandom_range(1, 3);
      default: a = $urandom_range(0, DEPTH + 2) * 4;
    endcase
    return a;
  endfunction

  initial begin
    int lat0, lat3;
    @(negedge clk); started = 1;
    @(negedge clk); rst = 1'b0;

    for (int i = 0; i < DEPTH; i++) begin
      ld_en = 1'b1; ld_addr = i * 4;
      ld_data = (i == 0) ? 32'h00500093 : (i == 1) ? 32'h00100113 : $urandom;
      @(negedge clk);
    end
    ld_en = 1'b0;

    do_req(32'h0);
    do_req(32'h4);

    rsp_ready = 1'b0;
    issue(32'h8);
    repeat (WS + 6) @(negedge clk);
    rsp_ready = 1'b1;
    wait_idle();

    do_req(32'h2);
    do_req(4 * DEPTH);
    do_req(32'hFFFF_FFFC);

    ld_en = 1'b1; ld_addr = 32'hC; ld_data = 32'h1234_5678;
    req_valid = 1'b1; req_addr = 32'hC;
    @(negedge clk);
    ld_en = 1'b0;
    do_req(32'hC);

    issue(32'h0);
    ld_en = 1'b1; ld_addr = 32'h0; ld_data = 32'hDEADBEEF;
    @(negedge clk);
    ld_en = 1'b0;
    wait_idle();
    do_req(32'h0);

    issue(32'h10);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    do_req(32'h10);

    for (int i = 0; i < 400; i++) begin
      req_valid = ($urandom_range(0, 1) == 1);
      req_addr  = rnd_addr();
      ld_en     = ($urandom_range(0, 4) == 0);
      ld_addr   = rnd_addr();
      ld_data   = $urandom;
      rsp_ready = ($urandom_range(0, 9) < 7);
      rst       = ($urandom_range(0, 49) == 0);
      @(negedge clk);
    end
    req_valid = 1'b0; ld_en = 1'b0; rst = 1'b0; rsp_ready = 1'b1;
    wait_idle();
    repeat (2) @(negedge clk);

    l_ld = 1'b1; l_ld_data = 32'hCAFE_0001;
    @(negedge clk);
    l_ld = 1'b0; l_req = 1'b1;
    @(negedge clk);
    l_req = 1'b0;
    lat0 = 0; lat3 = 0;
    for (int k = 1; k <= 10; k++) begin
      #2;
      if (r0_valid && lat0 == 0) begin lat0 = k; chk("ws0_instr", r0_instr, 32'hCAFE_0001); end
      if (r3_valid && lat3 == 0) begin lat3 = k; chk("ws3_instr", r3_instr, 32'hCAFE_0001); end
      @(negedge clk);
    end
    chk("ws0_latency", lat0, 32'd1);
    chk("ws3_latency", lat3, 32'd4);

    chk("exp_drain", exp_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
